router_out_arb: RTL and testbench

Packet-level round-robin scheduler that shares one downstream output link between the three router output FIFOs. It watches each FIFO's `empty`, grants one FIFO at a time and drives its `read_enb` for exactly one whole packet. It then presents the bytes on a valid/ready byte stream and rotates priority. It sits between the three FIFO instances and the shared output serializer.

---
 rtl/router_out_arb.sv | 170 +++++++++++++++++
 tb/tb_router_out_arb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_arb.sv
// Packet-level round-robin scheduler sharing one output byte stream among three router FIFOs.
// Define ROUTER_ARB_TIMEOUT_EN to compile in the no-progress abort with per-FIFO soft_reset.
module router_out_arb #(
    parameter int NUM_FIFO = 3,
    parameter int TIMEOUT  = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_FIFO-1:0]   empty,
    input  logic [8*NUM_FIFO-1:0] fifo_data,
    output logic [NUM_FIFO-1:0]   read_enb,
    output logic [NUM_FIFO-1:0]   soft_reset,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [NUM_FIFO-1:0]   grant,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} state_t;

    state_t     state;
    logic [1:0] gidx;
    logic [1:0] ptr;
    logic [1:0] sel;
    logic [1:0] cand;
    logic       found;
    logic [6:0] count;      // reads still to issue for the granted packet
    logic       in_flight;
    logic       rd_issue;
    logic       accept;
    logic       abort;
    logic [7:0] fifo_byte;

    if (NUM_FIFO != 3 || TIMEOUT < 1) begin : g_param_check
        $error("router_out_arb supports NUM_FIFO == 3 and TIMEOUT >= 1 only");
    end

    function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    always_comb begin
        case (gidx)
            2'd0:    fifo_byte = fifo_data[7:0];
            2'd1:    fifo_byte = fifo_data[15:8];
            default: fifo_byte = fifo_data[23:16];
        endcase
    end

    // First non-empty FIFO at or after ptr, wrapping modulo 3.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        sel   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_FIFO; k++) begin
            if (!found && !empty[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
            cand = wrap_inc(cand);
        end
    end

    // NOTE: read_enb is decoded from registered state and this cycle's empty/out_ready, so the header read goes out in the first granted cycle.
    always_comb begin
        read_enb = '0;
        if ((state == HDR || state == BODY) && count != 7'd0 && !in_flight
            && !empty[gidx] && (!out_valid || out_ready))
            read_enb[gidx] = 1'b1;
    end

    assign rd_issue = |read_enb;
    assign accept   = out_valid && out_ready;

`ifdef ROUTER_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_cnt;

    assign abort = busy && !rd_issue && !accept && (stall_cnt == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            soft_reset <= '0;
        end else begin
            soft_reset <= '0;
            if (abort)
                soft_reset[gidx] <= 1'b1;
            if (!busy || rd_issue || accept || abort)
                stall_cnt <= '0;
            else
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign abort      = 1'b0;
    assign soft_reset = '0;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gidx      <= 2'd0;
            ptr       <= 2'd0;
            count     <= 7'd0;
            in_flight <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            count     <= 7'd0;
            in_flight <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            ptr       <= wrap_inc(gidx);
        end else begin
            in_flight <= rd_issue;
            if (rd_issue)
                count <= count - 7'd1;

            // The output register is always free when a byte returns, since reads wait for it.
            if (in_flight) begin
                out_data  <= fifo_byte;
                out_valid <= 1'b1;
                out_last  <= (state == BODY) && (count == 7'd0);
            end else if (accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        gidx  <= sel;
                        grant <= NUM_FIFO'(1) << sel;
                        busy  <= 1'b1;
                        count <= 7'd1;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (in_flight) begin
                        count <= {1'b0, fifo_byte[7:2]} + 7'd1;
                        state <= BODY;
                    end
                end
                BODY: begin
                    if (in_flight && count == 7'd0)
                        state <= DONE;
                end
                DONE: begin
                    if (accept) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= wrap_inc(gidx);
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_router_out_arb.sv
// Self-checking bench for router_out_arb: FIFO emulation, packet-level reference model and directed tests.
module tb_router_out_arb;
    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic [2:0]  empty     = 3'b111;
    logic [23:0] fifo_data = '0;
    logic        out_ready = 1'b1;
    logic [2:0]  read_enb, soft_reset, grant;
    logic [7:0]  out_data;
    logic        out_valid, out_last, busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b1;

    logic [7:0] fq [3][$];      // emulated FIFO contents
    logic [7:0] xq [3][$];      // bytes each FIFO must still deliver downstream
    logic [8:0] out_log [$];    // accepted {last, data}
    logic [2:0] grant_log [$];  // each new non-zero grant
    logic [8:0] exp_log [$];
    logic [2:0] exp_grants [$];
    logic [2:0] rd_s = '0;

    router_out_arb dut (
        .clock(clock), .reset(reset), .empty(empty), .fifo_data(fifo_data),
        .read_enb(read_enb), .soft_reset(soft_reset), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic upd_empty();
        for (int i = 0; i < 3; i++) empty[i] = (fq[i].size() == 0);
    endtask

    task automatic push(input int f, input logic [7:0] b);
        fq[f].push_back(b);
        xq[f].push_back(b);
        upd_empty();
    endtask

    task automatic push_pkt(input int f, input int len, input logic [7:0] base, input logic [7:0] par);
        push(f, {6'(len), 2'(f)});
        for (int k = 0; k < len; k++) push(f, base + 8'(k));
        push(f, par);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) begin
            fq[i].delete();
            xq[i].delete();
        end
        fifo_data = '0;
        rd_s      = '0;
        out_ready = 1'b1;
        upd_empty();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic clear_logs();
        out_log.delete();
        grant_log.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(xq[0].size() == 0 && xq[1].size() == 0 && xq[2].size() == 0 && grant == 3'b000)
               && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_done_in_time"}, n < budget, 1);
    endtask

    task automatic wait_log(input string name, input int cnt, input int budget);
        int n = 0;
        while (out_log.size() < cnt && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_bytes_in_time"}, n < budget, 1);
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, out_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < out_log.size(); i++)
            check($sformatf("%s_byte%0d", name, i), out_log[i], exp_log[i]);
    endtask

    task automatic check_grants(input string name);
        check({name, "_count"}, grant_log.size(), exp_grants.size());
        for (int i = 0; i < exp_grants.size() && i < grant_log.size(); i++)
            check($sformatf("%s_grant%0d", name, i), grant_log[i], exp_grants[i]);
    endtask

    // FIFO emulation: a read in one cycle presents its byte in the next.
    always @(negedge clock) rd_s = read_enb;

    always @(posedge clock) begin
        #1;
        for (int i = 0; i < 3; i++)
            if (rd_s[i] && fq[i].size() != 0) fifo_data[8*i +: 8] = fq[i].pop_front();
        upd_empty();
    end

    // Packet-level reference model, checked every cycle between edges.
    logic [2:0] m_grant, m_rd, p_grant;
    int         m_g, m_ptr, m_left, m_acc, m_total;
    logic       m_inflight, m_v, p_stall, p_last, accepted, found;
    logic [7:0] p_data, exp_b, hb;

    always @(negedge clock) begin
        if (reset) begin
            m_grant = '0; m_g = 0; m_ptr = 0; m_left = 0; m_acc = 0; m_total = 0;
            m_inflight = 1'b0; m_v = 1'b0; p_stall = 1'b0; p_grant = '0;
        end else if (model_on) begin
            check("grant", grant, m_grant);
            check("busy", busy, m_grant != 3'b000);
            check("soft_reset_idle", soft_reset, 0);
            m_rd = '0;
            if (m_grant != 3'b000 && m_left > 0 && !m_inflight && !empty[m_g] && (!m_v || out_ready))
                m_rd[m_g] = 1'b1;
            check("read_enb", read_enb, m_rd);
            check("out_valid", out_valid, m_v);
            if (p_stall) begin
                check("hold_data", out_data, p_data);
                check("hold_last", out_last, p_last);
            end
            if (grant != 3'b000 && p_grant == 3'b000) grant_log.push_back(grant);
            accepted = m_v && out_ready;
            if (accepted) begin
                m_acc++;
                check("byte_expected", xq[m_g].size() != 0, 1);
                exp_b = (xq[m_g].size() != 0) ? xq[m_g].pop_front() : 8'h00;
                check("out_data", out_data, exp_b);
                check("out_last", out_last, m_acc == m_total);
                out_log.push_back({out_last, out_data});
            end
            p_stall = m_v && !out_ready;
            p_data  = out_data;
            p_last  = out_last;
            p_grant = grant;

            m_v = m_inflight ? 1'b1 : (accepted ? 1'b0 : m_v);
            m_inflight = |m_rd;
            if (|m_rd) m_left--;
            if (m_grant == 3'b000) begin
                found = 1'b0;
                for (int k = 0; k < 3; k++)
                    if (!found && !empty[(m_ptr + k) % 3]) begin
                        m_g = (m_ptr + k) % 3;
                        found = 1'b1;
                    end
                if (found) begin
                    m_grant = 3'b001 << m_g;
                    hb      = xq[m_g][0];
                    m_total = int'(hb[7:2]) + 2;
                    m_left  = m_total;
                    m_acc   = 0;
                end
            end else if (accepted && m_acc == m_total) begin
                m_grant = '0;
                m_ptr   = (m_g + 1) % 3;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running, expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset with all FIFOs empty, then 20 idle cycles.
        do_reset();
        check("rst_grant", grant, 0);
        check("rst_out_data", out_data, 0);
        tick(20);
        check("idle_grant", grant, 0);
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_valid, 0);

        // Single len-3 packet from FIFO0.
        clear_logs();
        push(0, 8'h0C); push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h3C);
        wait_done("t2", 100);
        exp_log = '{9'h00C, 9'h011, 9'h022, 9'h033, 9'h13C};
        check_log("t2_stream");
        exp_grants = '{3'b001};
        check_grants("t2");
        // ptr is now 1: FIFO1 must win over FIFO0.
        clear_logs();
        push_pkt(0, 0, 8'h00, 8'hE0);
        push_pkt(1, 0, 8'h00, 8'hE1);
        wait_done("t2b", 100);
        exp_grants = '{3'b010, 3'b001};
        check_grants("t2_ptr");
        exp_log = '{9'h001, 9'h1E1, 9'h000, 9'h1E0};
        check_log("t2b_stream");

        // Round robin over three len-0 packets from ptr 0, then from ptr 1.
        do_reset();
        clear_logs();
        push_pkt(0, 0, 8'h00, 8'hB0); push_pkt(1, 0, 8'h00, 8'hB1); push_pkt(2, 0, 8'h00, 8'hB2);
        wait_done("t3a", 200);
        exp_grants = '{3'b001, 3'b010, 3'b100};
        check_grants("t3a");
        exp_log = '{9'h000, 9'h1B0, 9'h001, 9'h1B1, 9'h002, 9'h1B2};
        check_log("t3a_stream");
        push_pkt(0, 0, 8'h00, 8'hC0);
        wait_done("t3b", 100);
        clear_logs();
        push_pkt(0, 0, 8'h00, 8'hC0); push_pkt(1, 0, 8'h00, 8'hC1); push_pkt(2, 0, 8'h00, 8'hC2);
        wait_done("t3c", 200);
        exp_grants = '{3'b010, 3'b100, 3'b001};
        check_grants("t3c");

        // Downstream backpressure for 10 cycles mid-packet.
        clear_logs();
        push_pkt(2, 4, 8'hA0, 8'h77);
        wait_log("t4", 2, 50);
        out_ready = 1'b0;
        tick(11);
        check("t4_stall_data", out_data, 8'hA1);
        check("t4_stall_valid", out_valid, 1);
        check("t4_stall_read", read_enb, 0);
        check("t4_stall_count", out_log.size(), 2);
        out_ready = 1'b1;
        wait_done("t4", 100);
        exp_log = '{9'h012, 9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3, 9'h177};
        check_log("t4_stream");

        // FIFO1 runs dry after its header; grant is held until the rest arrives.
        do_reset();
        clear_logs();
        push(1, 8'h05);
        tick(10);
        check("t5_grant_held", grant, 3'b010);
        check("t5_busy_held", busy, 1);
        check("t5_no_read", read_enb, 0);
        check("t5_header_only", out_log.size(), 1);
        push(1, 8'h99); push(1, 8'h66);
        wait_done("t5", 100);
        exp_log = '{9'h005, 9'h099, 9'h166};
        check_log("t5_stream");

        // Reset asserted mid-packet clears every output at once.
        clear_logs();
        push_pkt(0, 10, 8'h40, 8'h5A);
        wait_log("t6", 2, 50);
        reset = 1'b1;
        #1;
        check("t6_read_enb", read_enb, 0);
        check("t6_soft_reset", soft_reset, 0);
        check("t6_out_data", out_data, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_out_last", out_last, 0);
        check("t6_grant", grant, 0);
        check("t6_busy", busy, 0);
        flush();
        tick(2);
        reset = 1'b0;
        tick(5);
        clear_logs();
        push_pkt(2, 1, 8'h31, 8'hCC);
        wait_done("t6b", 100);
        exp_log = '{9'h006, 9'h031, 9'h1CC};
        check_log("t6_after");

`ifdef ROUTER_ARB_TIMEOUT_EN
        // Stalled FIFO2 packet is aborted after the no-progress limit.
        do_reset();
        model_on = 1'b0;
        push_pkt(2, 5, 8'h70, 8'h0F);
        n = 0;
        while (!out_valid && n < 20) begin tick(1); n++; end
        out_ready = 1'b0;
        n = 0;
        while (soft_reset == 3'b000 && n < 60) begin tick(1); n++; end
        check("to_fired", n < 60, 1);
        check("to_soft_reset", soft_reset, 3'b100);
        check("to_grant", grant, 0);
        check("to_out_valid", out_valid, 0);
        tick(1);
        check("to_pulse_len", soft_reset, 0);
        fq[2].delete(); xq[2].delete(); upd_empty();
        out_ready = 1'b1;
        push_pkt(0, 0, 8'h00, 8'hD0);
        push_pkt(2, 0, 8'h00, 8'hD2);
        tick(2);
        check("to_ptr", grant, 3'b001);
        do_reset();
        model_on = 1'b1;
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
